// File: rtl/wm_pkg.sv
// Shared types and constants for the washing_machine support blocks.
//   phase_e     : phase index, also the bit position of each phase enable/done
//   state_e     : wash_phase_timer FSM states
//   CLOTH_*     : cloth_type codes
//   TEMP_*      : temp_select codes
//   *_LEN/_UNIT : base phase lengths in timer ticks
//   clamp_len   : limits a raw length to the 2..32 tick range
package wm_pkg;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        WASH  = 3'd1,
        RINSE = 3'd2,
        SPIN  = 3'd3,
        DRAIN = 3'd4,
        DRY   = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_e;

    localparam logic [1:0] CLOTH_COTTON    = 2'b00;
    localparam logic [1:0] CLOTH_SYNTHETIC = 2'b01;
    localparam logic [1:0] CLOTH_DELICATE  = 2'b10;
    localparam logic [1:0] CLOTH_WOOL      = 2'b11;

    localparam logic [1:0] TEMP_COLD = 2'b00;
    localparam logic [1:0] TEMP_HOT  = 2'b11;

    localparam logic [6:0] FILL_LEN       = 7'd4;
    localparam logic [6:0] FILL_HOT_LEN   = 7'd6;
    localparam logic [6:0] RINSE_LEN      = 7'd6;
    localparam logic [6:0] DRAIN_LEN      = 7'd4;
    localparam logic [6:0] WASH_UNIT      = 7'd8;
    localparam logic [6:0] DRY_UNIT       = 7'd4;
    localparam logic [6:0] SPIN_COTTON    = 7'd8;
    localparam logic [6:0] SPIN_SYNTHETIC = 7'd6;
    localparam logic [6:0] SPIN_GENTLE    = 7'd2;

    localparam logic [6:0] MIN_LEN = 7'd2;
    localparam logic [6:0] MAX_LEN = 7'd32;

    function automatic logic [5:0] clamp_len(input logic [6:0] raw);
        if (raw < MIN_LEN)
            return MIN_LEN[5:0];
        else if (raw > MAX_LEN)
            return MAX_LEN[5:0];
        else
            return raw[5:0];
    endfunction

endpackage

// File: rtl/phase_len_lut.sv
// Programme table: phase length in ticks for a given phase and programme.
//   phase          : phase being loaded
//   cloth_type     : 00 cotton, 01 synthetic, 10 delicate, 11 wool
//   cycle_duration : wash-length code
//   temp_select    : 00 cold .. 11 hot
//   len            : phase length in ticks, 2..32
module phase_len_lut
    import wm_pkg::*;
(
    input  phase_e     phase,
    input  logic [1:0] cloth_type,
    input  logic [1:0] cycle_duration,
    input  logic [1:0] temp_select,
    output logic [5:0] len
);

    logic [6:0] raw;
    logic       gentle;

    assign gentle = (cloth_type == CLOTH_DELICATE) || (cloth_type == CLOTH_WOOL);

    always_comb begin
        raw = '0;
        case (phase)
            FILL:  raw = (temp_select == TEMP_HOT) ? FILL_HOT_LEN : FILL_LEN;
            WASH: begin
                raw = WASH_UNIT * (7'(cycle_duration) + 7'd1);
                if (gentle)
                    raw = raw >> 1;
            end
            RINSE: raw = RINSE_LEN;
            SPIN: begin
                case (cloth_type)
                    CLOTH_COTTON:    raw = SPIN_COTTON;
                    CLOTH_SYNTHETIC: raw = SPIN_SYNTHETIC;
                    default:         raw = SPIN_GENTLE;
                endcase
            end
            DRAIN: raw = DRAIN_LEN;
            DRY:   raw = DRY_UNIT * (7'(temp_select) + 7'd1);
            default: raw = '0;
        endcase
        len = clamp_len(raw);
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer for washing_machine: times each enabled phase from the
// programme table and answers with a one-cycle done pulse.
//   clk, reset_n                  : clock, async active-low reset
//   lock_door                     : door lock request
//   fill_water..dry               : phase enables from the controller
//   pause, resume                 : hold / continue the running phase
//   temp_select, cloth_type,
//   cycle_duration                : programme, latched when a phase loads
//   door_locked                   : lock sensor emulation
//   fill_done..dry_done           : one-cycle done pulses
//   busy, paused                  : RUN or HOLD / HOLD
//   remaining                     : ticks left in the current phase
//   err                           : sticky, more than one enable seen high
module wash_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned LOCK_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lock_door,
    input  logic       fill_water,
    input  logic       wash,
    input  logic       rinse,
    input  logic       spin,
    input  logic       drain,
    input  logic       dry,
    input  logic       pause,
    input  logic       resume,
    input  logic [1:0] temp_select,
    input  logic [1:0] cloth_type,
    input  logic [1:0] cycle_duration,
    output logic       door_locked,
    output logic       fill_done,
    output logic       wash_done,
    output logic       rinse_done,
    output logic       spin_done,
    output logic       drain_done,
    output logic       dry_done,
    output logic       busy,
    output logic       paused,
    output logic [5:0] remaining,
    output logic       err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int LW = $clog2(LOCK_TICKS + 2);

    state_e        state;
    phase_e        cur_phase;
    phase_e        load_idx;
    logic [5:0]    phase_en;
    logic [5:0]    done_vec;
    logic [5:0]    lut_len;
    logic [PW-1:0] presc;
    logic          tick;
    logic          any_en;
    logic          multi_en;
    logic [PW-1:0] lock_presc;
    logic [LW-1:0] lock_ticks;

    assign phase_en = {dry, drain, spin, rinse, wash, fill_water};
    assign any_en   = |phase_en;
    assign multi_en = |(phase_en & (phase_en - 6'd1));
    assign tick     = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        load_idx = FILL;
        if      (phase_en[0]) load_idx = FILL;
        else if (phase_en[1]) load_idx = WASH;
        else if (phase_en[2]) load_idx = RINSE;
        else if (phase_en[3]) load_idx = SPIN;
        else if (phase_en[4]) load_idx = DRAIN;
        else if (phase_en[5]) load_idx = DRY;
    end

    phase_len_lut u_lut (
        .phase          (load_idx),
        .cloth_type     (cloth_type),
        .cycle_duration (cycle_duration),
        .temp_select    (temp_select),
        .len            (lut_len)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_phase <= FILL;
            presc     <= '0;
            remaining <= '0;
            done_vec  <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            err       <= 1'b0;
        end else begin
            done_vec <= '0;
            if (multi_en) begin
                err       <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
                paused    <= 1'b0;
                presc     <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_en) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            paused    <= 1'b0;
                            cur_phase <= load_idx;
                            remaining <= lut_len;
                            presc     <= '0;
                        end
                    end
                    RUN, HOLD: begin
                        if (!phase_en[cur_phase]) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            paused    <= 1'b0;
                            presc     <= '0;
                            remaining <= '0;
                        end else if (state == RUN && pause) begin
                            state  <= HOLD;
                            paused <= 1'b1;
                        end else if (!pause && (state == RUN || resume)) begin
                            // The resume edge itself advances the prescaler, so
                            // a hold stretches the phase by its HOLD cycles only.
                            state  <= RUN;
                            paused <= 1'b0;
                            if (tick) begin
                                presc     <= '0;
                                remaining <= remaining - 6'd1;
                                if (remaining == 6'd1) begin
                                    done_vec[cur_phase] <= 1'b1;
                                    state               <= DONE;
                                    busy                <= 1'b0;
                                end
                            end else begin
                                presc <= presc + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (!phase_en[cur_phase])
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Door lock: count ticks while requested; the extra cycle after the
    // last tick places the rising edge at LOCK_TICKS*TICK_DIV after sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_presc  <= '0;
            lock_ticks  <= '0;
            door_locked <= 1'b0;
        end else if (!lock_door) begin
            lock_presc  <= '0;
            lock_ticks  <= '0;
            door_locked <= 1'b0;
        end else if (lock_ticks == LW'(LOCK_TICKS)) begin
            door_locked <= 1'b1;
        end else if (lock_presc == PW'(TICK_DIV - 1)) begin
            lock_presc <= '0;
            lock_ticks <= lock_ticks + 1'b1;
        end else begin
            lock_presc <= lock_presc + 1'b1;
        end
    end

    assign fill_done  = done_vec[FILL];
    assign wash_done  = done_vec[WASH];
    assign rinse_done = done_vec[RINSE];
    assign spin_done  = done_vec[SPIN];
    assign drain_done = done_vec[DRAIN];
    assign dry_done   = done_vec[DRY];

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: programme table vectors,
// hand-written pause/abort/error/reset sequences and randomized stimulus,
// all compared each cycle against a job-level reference model.
module tb_wash_phase_timer;

    localparam int D = 4;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock_door = 1'b0;
    logic       fill_water = 1'b0, wash = 1'b0, rinse = 1'b0;
    logic       spin = 1'b0, drain = 1'b0, dry = 1'b0;
    logic       pause = 1'b0, resume = 1'b0;
    logic [1:0] temp_select = 2'b00, cloth_type = 2'b00, cycle_duration = 2'b00;
    logic       door_locked;
    logic       fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
    logic       busy, paused, err;
    logic [5:0] remaining;
    logic [5:0] en_v, done_v;

    assign en_v   = {dry, drain, spin, rinse, wash, fill_water};
    assign done_v = {dry_done, drain_done, spin_done, rinse_done, wash_done, fill_done};

    always #5 clk = ~clk;

    wash_phase_timer #(.TICK_DIV(D), .LOCK_TICKS(L)) dut (
        .clk(clk), .reset_n(reset_n), .lock_door(lock_door),
        .fill_water(fill_water), .wash(wash), .rinse(rinse), .spin(spin),
        .drain(drain), .dry(dry), .pause(pause), .resume(resume),
        .temp_select(temp_select), .cloth_type(cloth_type),
        .cycle_duration(cycle_duration), .door_locked(door_locked),
        .fill_done(fill_done), .wash_done(wash_done), .rinse_done(rinse_done),
        .spin_done(spin_done), .drain_done(drain_done), .dry_done(dry_done),
        .busy(busy), .paused(paused), .remaining(remaining), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Programme rules written directly as arithmetic.
    function automatic int spec_len(int ph, int cloth, int cd, int temp);
        int v;
        case (ph)
            0: v = (temp == 3) ? 6 : 4;
            1: begin v = 8 * (cd + 1); if (cloth >= 2) v = v / 2; end
            2: v = 6;
            3: v = (cloth == 0) ? 8 : (cloth == 1) ? 6 : 2;
            4: v = 4;
            5: v = 4 * (temp + 1);
            default: v = 0;
        endcase
        if (v < 2) v = 2;
        if (v > 32) v = 32;
        return v;
    endfunction

    // Reference model: a job is a phase with a cycle budget of len*D running
    // cycles; remaining is len minus whole ticks consumed.
    bit         m_job, m_hold, m_wait, m_err, m_door;
    int         m_ph, m_len, m_el, m_rem, m_lk;
    logic [5:0] m_done;

    task automatic model_reset();
        m_job = 0; m_hold = 0; m_wait = 0; m_err = 0; m_door = 0;
        m_ph = 0; m_len = 0; m_el = 0; m_rem = 0; m_lk = -1; m_done = '0;
    endtask

    task automatic model_update();
        int n;
        if (!reset_n) begin
            model_reset();
            return;
        end
        n = $countones(en_v);
        m_done = '0;
        if (n > 1) begin
            m_err = 1; m_job = 0; m_hold = 0; m_wait = 0; m_rem = 0;
        end else if (m_wait) begin
            if (!en_v[m_ph]) m_wait = 0;
        end else if (m_job) begin
            if (!en_v[m_ph]) begin
                m_job = 0; m_hold = 0; m_rem = 0;
            end else if (!m_hold && pause) begin
                m_hold = 1;
            end else if (m_hold && !(resume && !pause)) begin
                m_hold = 1;
            end else begin
                m_hold = 0;
                m_el++;
                m_rem = m_len - m_el / D;
                if (m_el == m_len * D) begin
                    m_done[m_ph] = 1'b1;
                    m_job = 0;
                    m_wait = 1;
                end
            end
        end else if (n == 1) begin
            for (int i = 5; i >= 0; i--) if (en_v[i]) m_ph = i;
            m_len = spec_len(m_ph, cloth_type, cycle_duration, temp_select);
            m_el = 0; m_rem = m_len; m_job = 1; m_hold = 0;
        end
        if (lock_door) begin
            m_lk++;
            m_door = (m_lk >= L * D);
        end else begin
            m_lk = -1;
            m_door = 0;
        end
    endtask

    task automatic compare_all();
        check("busy", busy, m_job);
        check("paused", paused, m_hold);
        check("remaining", remaining, m_rem);
        check("err", err, m_err);
        check("door_locked", door_locked, m_door);
        check("done_pulses", done_v, m_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_en(input logic [5:0] v);
        {dry, drain, spin, rinse, wash, fill_water} = v;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_paused"}, paused, 0);
        check({name, "_remaining"}, remaining, 0);
        check({name, "_err"}, err, 0);
        check({name, "_door"}, door_locked, 0);
        check({name, "_done"}, done_v, 0);
    endtask

    typedef struct {
        logic [5:0] en;
        logic [1:0] cloth, cd, temp;
        int         len;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, e;
        bit seen;

        tbl[0]  = '{6'b000010, 2'd0, 2'd1, 2'd0, 16}; // cotton wash cd=01
        tbl[1]  = '{6'b000001, 2'd0, 2'd0, 2'd3, 6};  // hot fill
        tbl[2]  = '{6'b000001, 2'd1, 2'd3, 2'd1, 4};  // warm fill
        tbl[3]  = '{6'b000010, 2'd2, 2'd3, 2'd0, 16}; // delicate wash cd=11
        tbl[4]  = '{6'b000010, 2'd3, 2'd0, 2'd0, 4};  // wool wash cd=00
        tbl[5]  = '{6'b000010, 2'd1, 2'd3, 2'd2, 32}; // synthetic wash max
        tbl[6]  = '{6'b000100, 2'd3, 2'd2, 2'd3, 6};  // rinse
        tbl[7]  = '{6'b001000, 2'd0, 2'd0, 2'd0, 8};  // cotton spin
        tbl[8]  = '{6'b001000, 2'd1, 2'd0, 2'd0, 6};  // synthetic spin
        tbl[9]  = '{6'b001000, 2'd3, 2'd0, 2'd0, 2};  // wool spin, minimum
        tbl[10] = '{6'b010000, 2'd2, 2'd1, 2'd1, 4};  // drain
        tbl[11] = '{6'b100000, 2'd0, 2'd0, 2'd0, 4};  // cold dry
        tbl[12] = '{6'b100000, 2'd0, 2'd0, 2'd3, 16}; // hot dry

        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Table vectors; programme scrambled after load must not matter.
        for (int i = 0; i < 13; i++) begin
            cloth_type = tbl[i].cloth; cycle_duration = tbl[i].cd; temp_select = tbl[i].temp;
            set_en(tbl[i].en);
            step();
            check("tbl_load_remaining", remaining, tbl[i].len);
            check("tbl_load_busy", busy, 1);
            cloth_type = 2'($urandom); cycle_duration = 2'($urandom); temp_select = 2'($urandom);
            cnt = 0;
            while (cnt < 200 && done_v == 0) begin
                step();
                cnt++;
            end
            check("tbl_done_cycles", cnt, tbl[i].len * D);
            check("tbl_done_which", done_v, tbl[i].en);
            step();
            check("tbl_done_one_cycle", done_v, 0);
            set_en('0);
            step();
            step();
        end

        // Door lock timing and release.
        lock_door = 1'b1;
        step();
        cnt = 0;
        while (cnt < 50 && !door_locked) begin
            step();
            cnt++;
        end
        check("lock_cycles", cnt, L * D);
        lock_door = 1'b0;
        step();
        check("lock_release", door_locked, 0);

        // Wool spin with pause at cycle 3, resume 10 cycles later.
        cloth_type = 2'd3;
        set_en(6'b001000);
        step(); e = 0;
        step(); step(); e = 2;
        pause = 1'b1;
        step(); e = 3;
        pause = 1'b0;
        check("spin_paused", paused, 1);
        check("spin_hold_remaining", remaining, 2);
        step(); step(); e = 5;
        pause = 1'b1; resume = 1'b1;
        step(); e = 6;
        pause = 1'b0; resume = 1'b0;
        check("spin_pause_wins", paused, 1);
        while (e < 12) begin step(); e++; end
        resume = 1'b1;
        step(); e = 13;
        resume = 1'b0;
        check("spin_resumed", paused, 0);
        while (e < 60 && done_v == 0) begin step(); e++; end
        check("spin_done_edge", e, 18);
        check("spin_done_which", done_v, 6'b001000);
        set_en('0);
        step(); step();

        // Delicate wash aborted at cycle 20.
        cloth_type = 2'd2; cycle_duration = 2'd3;
        set_en(6'b000010);
        step();
        seen = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (done_v != 0) seen = 1;
        end
        set_en('0);
        step();
        check("abort_busy", busy, 0);
        check("abort_remaining", remaining, 0);
        check("abort_no_done", {31'd0, seen | (done_v != 0)}, 0);
        step();

        // Two enables together: sticky error, no pulses.
        set_en(6'b001100);
        step();
        check("err_set", err, 1);
        check("err_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_v != 0) seen = 1;
        end
        check("err_no_done", {31'd0, seen}, 0);
        set_en('0);
        step();
        check("err_sticky", err, 1);
        set_en(6'b010000);
        step();
        check("err_load_after", busy, 1);
        check("err_still_set", err, 1);
        set_en('0);
        step();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("err_cleared_by_reset", err, 0);
        step();
        reset_n = 1'b1;
        step();

        // Full programme driven as the controller would, reset mid-dry.
        cloth_type = 2'd0; cycle_duration = 2'd2; temp_select = 2'd2;
        lock_door = 1'b1;
        for (int p = 0; p < 6; p++) begin
            set_en(6'(1 << p));
            step();
            if (p == 5) begin
                for (int i = 0; i < 20; i++) step();
                reset_n = 1'b0;
                model_reset();
                #1;
                check_all_zero("midreset");
            end else begin
                cnt = 0;
                while (cnt < 200 && done_v == 0) begin step(); cnt++; end
                check("seq_done_cycles", cnt, spec_len(p, 0, 2, 2) * D);
                check("seq_done_which", done_v, 6'(1 << p));
                set_en('0);
                step();
            end
        end
        step();
        set_en('0);
        lock_door = 1'b0;
        reset_n = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (en_v == 0) begin
                if ($urandom_range(0, 9) == 0) set_en(6'(1 << $urandom_range(0, 5)));
            end else if (m_wait && $urandom_range(0, 2) == 0) begin
                set_en('0);
            end else if ($urandom_range(0, 299) == 0) begin
                set_en('0);
            end else if ($urandom_range(0, 499) == 0) begin
                set_en(en_v | 6'(1 << $urandom_range(0, 5)));
            end
            pause  = ($urandom_range(0, 19) == 0);
            resume = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
                cloth_type = 2'($urandom); cycle_duration = 2'($urandom); temp_select = 2'($urandom);
            end
            if ($urandom_range(0, 29) == 0) lock_door = ~lock_door;
            if ($urandom_range(0, 399) == 0 || (m_err && $urandom_range(0, 49) == 0)) begin
                reset_n = 1'b0;
                model_reset();
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
